uart_pic_rx_ctrl: RTL and testbench

Sequencer between the UART byte receiver and the SDRAM write FIFO in the UART-to-SDRAM-to-VGA picture path. It fixes the receiver's baud selection and, once armed, assembles received bytes into RGB565 pixels. It counts pixels up to one full frame and hands each pixel to the FIFO over a valid/ready handshake. It flags inter-byte timeouts and pixel overruns, and pulses `frame_done` after the last pixel of a frame is accepted.

---
 rtl/uart_pic_rx_ctrl_if.sv | 9 +
 rtl/uart_pic_rx_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_uart_pic_rx_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pic_rx_ctrl_if.sv
// Pixel stream handshake between uart_pic_rx_ctrl (master) and the SDRAM write FIFO (slave).
interface uart_pic_rx_ctrl_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, output pix_valid, input  pix_ready);
  modport slave  (input  pix_data, input  pix_valid, output pix_ready);
endinterface

// File: rtl/uart_pic_rx_ctrl.sv
// uart_pic_rx_ctrl: sequences UART bytes into RGB565 pixels for the SDRAM write FIFO,
// counts pixels per frame, flags inter-byte timeouts and dropped pixels.
// Build option: define PIX_RGB888_EN to take 3 bytes (R,G,B) per pixel and pack to RGB565.
module uart_pic_rx_ctrl #(
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned BAUD_SEL    = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               rx_done,
  input  logic [7:0]                         rx_data,
  output logic [3:0]                         baud_set,
  uart_pic_rx_ctrl_if.master                 pix,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]   pix_cnt,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               err_timeout,
  output logic                               err_ovf,
  input  logic                               err_clr
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2,
    S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte0_q, byte0_d;
`ifdef PIX_RGB888_EN
  logic [7:0]       byte1_q, byte1_d;
`endif
  logic [15:0]      pix_data_q, pix_data_d;
  logic             pix_valid_q, pix_valid_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             frame_done_q, frame_done_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_ovf_q, err_ovf_d;

  logic             tmo_run;
  logic             tmo_hit;
  logic             form;
  logic [15:0]      new_pix;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      byte0_q       <= '0;
`ifdef PIX_RGB888_EN
      byte1_q       <= '0;
`endif
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_cnt_q     <= '0;
      tmo_q         <= '0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte0_q       <= byte0_d;
`ifdef PIX_RGB888_EN
      byte1_q       <= byte1_d;
`endif
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      pix_cnt_q     <= pix_cnt_d;
      tmo_q         <= tmo_d;
      frame_done_q  <= frame_done_d;
      err_timeout_q <= err_timeout_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  // Next-state, pixel assembly, handshake, timeout and error logic
  always_comb begin
    state_d       = state_q;
    byte0_d       = byte0_q;
`ifdef PIX_RGB888_EN
    byte1_d       = byte1_q;
`endif
    pix_data_d    = pix_data_q;
    pix_valid_d   = pix_valid_q;
    pix_cnt_d     = pix_cnt_q;
    tmo_d         = '0;
    frame_done_d  = 1'b0;
    err_timeout_d = err_timeout_q;
    err_ovf_d     = err_ovf_q;
    form          = 1'b0;
    new_pix       = '0;
    tmo_hit       = 1'b0;

    if (pix_valid_q && pix.pix_ready) begin
      pix_valid_d = 1'b0;
    end

    // Clear first so that an error event in the same cycle still sets the flag
    if (err_clr) begin
      err_timeout_d = 1'b0;
      err_ovf_d     = 1'b0;
    end

    // Timeout only arms once a frame has received data; waiting for the first byte is unbounded
`ifdef PIX_RGB888_EN
    tmo_run = ((state_q == S_B0) && (pix_cnt_q != '0)) || (state_q == S_B1) || (state_q == S_B2);
`else
    tmo_run = ((state_q == S_B0) && (pix_cnt_q != '0)) || (state_q == S_B1);
`endif
    if (tmo_run && !rx_done) begin
      if (tmo_q == TMO_LAST) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_B0;
          pix_cnt_d = '0;
        end
      end
      S_B0: begin
        if (rx_done) begin
          byte0_d = rx_data;
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (rx_done) begin
`ifdef PIX_RGB888_EN
          byte1_d = rx_data;
          state_d = S_B2;
`else
          form    = 1'b1;
          new_pix = {byte0_q, rx_data};
`endif
        end
      end
      S_B2: begin
`ifdef PIX_RGB888_EN
        if (rx_done) begin
          form    = 1'b1;
          new_pix = {byte0_q[7:3], byte1_q[7:2], rx_data[7:3]};
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_FLUSH: begin
        // Finishing on the handshake cycle itself puts frame_done right after the final transfer
        if (!pix_valid_q || pix.pix_ready) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A dropped pixel still counts so the frame stays aligned to the byte stream
    if (form) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
      state_d   = (pix_cnt_q == LAST_PIX) ? S_FLUSH : S_B0;
      if (pix_valid_q && !pix.pix_ready) begin
        err_ovf_d = 1'b1;
      end else begin
        pix_data_d  = new_pix;
        pix_valid_d = 1'b1;
      end
    end

    if (tmo_hit) begin
      err_timeout_d = 1'b1;
      state_d       = S_IDLE;
    end
  end

  assign baud_set      = 4'(BAUD_SEL);
  assign pix.pix_data  = pix_data_q;
  assign pix.pix_valid = pix_valid_q;
  assign pix_cnt       = pix_cnt_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = frame_done_q;
  assign err_timeout   = err_timeout_q;
  assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_uart_pic_rx_ctrl.sv
// Testbench for uart_pic_rx_ctrl: small 4x2 frame, timeout of 100 cycles.
module tb_uart_pic_rx_ctrl;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int TMO   = 100;
  localparam int NPIX  = IMG_W * IMG_H;
`ifdef PIX_RGB888_EN
  localparam int BPP = 3;
`else
  localparam int BPP = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic       err_clr = 1'b0;
  logic [3:0] baud_set;
  logic [3:0] pix_cnt;
  logic       busy, frame_done, err_timeout, err_ovf;

  uart_pic_rx_ctrl_if pif();

  uart_pic_rx_ctrl #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .TIMEOUT_CYC(TMO),
    .BAUD_SEL(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .baud_set(baud_set),
    .pix(pif),
    .pix_cnt(pix_cnt),
    .busy(busy),
    .frame_done(frame_done),
    .err_timeout(err_timeout),
    .err_ovf(err_ovf),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  bq[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int fd_cnt = 0;

  // Scoreboard capture: transfers and frame_done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && pif.pix_valid && pif.pix_ready) got_q.push_back(pif.pix_data);
    if (frame_done) fd_cnt++;
  end

  // Reference pixel from the byte stream starting at index base
  function automatic logic [15:0] model_pix(input int base);
    int v;
`ifdef PIX_RGB888_EN
    v = ((int'(bq[base]) / 8) * 2048) + ((int'(bq[base+1]) / 4) * 32) + (int'(bq[base+2]) / 8);
`else
    v = int'(bq[base]) * 256 + int'(bq[base+1]);
`endif
    return 16'(v);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  // Sends bq[from..to-1] with short random gaps between bytes, none after the last
  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) begin
      send_byte(bq[i]);
      if (i != to - 1) tick($urandom_range(0, 3));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic gen_random(input int nbytes);
    bq.delete();
    for (int i = 0; i < nbytes; i++) bq.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic build_expected(input int base, input int first, input int last_excl);
    for (int p = first; p < last_excl; p++) exp_q.push_back(model_pix(base + p * BPP));
  endtask

  task automatic test_reset();
    checks++; if (baud_set !== 4'd4) begin errors++; $display("FAIL reset_baud: got %0d expected 4", baud_set); end
    checks++; if (pif.pix_data !== 16'h0) begin errors++; $display("FAIL reset_pix_data: got %h expected 0000", pif.pix_data); end
    checks++; if (pif.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b expected 0", pif.pix_valid); end
    checks++; if (pix_cnt !== 4'd0) begin errors++; $display("FAIL reset_pix_cnt: got %0d expected 0", pix_cnt); end
    checks++; if ({busy, frame_done, err_timeout, err_ovf} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, frame_done, err_timeout, err_ovf}); end
  endtask

  task automatic test_frame();
    bq.delete();
`ifdef PIX_RGB888_EN
    gen_random(NPIX * BPP);
`else
    bq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hFE, 8'hDC};
`endif
    exp_q.delete(); got_q.delete(); fd_cnt = 0;
    build_expected(0, 0, NPIX);
    pulse_start();
    checks++; if (busy !== 1'b1 || pix_cnt !== 4'd0) begin errors++; $display("FAIL frame_start: got busy=%b cnt=%0d expected busy=1 cnt=0", busy, pix_cnt); end
    send_range(0, NPIX * BPP);
    checks++; if (pif.pix_valid !== 1'b1 || pix_cnt !== 4'(NPIX)) begin errors++; $display("FAIL frame_last_pix: got valid=%b cnt=%0d expected valid=1 cnt=%0d", pif.pix_valid, pix_cnt, NPIX); end
    checks++; if (busy !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL frame_flush: got busy=%b done=%b expected busy=1 done=0", busy, frame_done); end
    tick(1);
    checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL frame_done_timing: got done=%b busy=%b expected done=1 busy=0", frame_done, busy); end
    tick(1);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse: got %b expected 0", frame_done); end
    checks++; if (got_q.size() !== NPIX) begin errors++; $display("FAIL frame_count: got %0d pixels expected %0d", got_q.size(), NPIX); end
    for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_pix%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
`ifndef PIX_RGB888_EN
    if (got_q.size() == NPIX) begin
      checks++; if (got_q[0] !== 16'h1234 || got_q[NPIX-1] !== 16'hFEDC) begin errors++; $display("FAIL frame_ends: got %h..%h expected 1234..fedc", got_q[0], got_q[NPIX-1]); end
    end
`endif
    checks++; if (fd_cnt !== 1 || pix_cnt !== 4'(NPIX)) begin errors++; $display("FAIL frame_summary: got done_pulses=%0d cnt=%0d expected 1 and %0d", fd_cnt, pix_cnt, NPIX); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      gen_random(NPIX * BPP);
      exp_q.delete(); got_q.delete(); fd_cnt = 0;
      build_expected(0, 0, NPIX);
      pulse_start();
      checks++; if (busy !== 1'b1 || pix_cnt !== 4'd0) begin errors++; $display("FAIL b2b_start%0d: got busy=%b cnt=%0d expected busy=1 cnt=0", f, busy, pix_cnt); end
      send_range(0, NPIX * BPP);
      tick(1);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_done%0d: got %b expected 1", f, frame_done); end
      tick(1);
      checks++; if (got_q.size() !== NPIX) begin errors++; $display("FAIL b2b_count%0d: got %0d expected %0d", f, got_q.size(), NPIX); end
      for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_pix%0d_%0d: got %h expected %h", f, i, got_q[i], exp_q[i]); end
      end
      checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL b2b_pulses%0d: got %0d expected 1", f, fd_cnt); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p1;
    gen_random(NPIX * BPP);
    exp_q.delete(); got_q.delete(); fd_cnt = 0;
    p1 = model_pix(0);
    exp_q.push_back(p1);
    build_expected(0, 2, NPIX);
    pif.pix_ready = 1'b0;
    pulse_start();
    send_range(0, BPP);
    checks++; if (pif.pix_valid !== 1'b1 || pif.pix_data !== p1 || pix_cnt !== 4'd1) begin errors++; $display("FAIL bp_first: got valid=%b data=%h cnt=%0d expected 1 %h 1", pif.pix_valid, pif.pix_data, pix_cnt, p1); end
    tick(2);
    send_range(BPP, 2 * BPP);
    checks++; if (pif.pix_data !== p1 || pif.pix_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got valid=%b data=%h expected 1 %h", pif.pix_valid, pif.pix_data, p1); end
    checks++; if (err_ovf !== 1'b1 || pix_cnt !== 4'd2) begin errors++; $display("FAIL bp_ovf: got ovf=%b cnt=%0d expected 1 2", err_ovf, pix_cnt); end
    pulse_clr();
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL bp_clr: got %b expected 0", err_ovf); end
    send_range(2 * BPP, 3 * BPP - 1);
    pif.pix_ready = 1'b1;
    send_byte(bq[3 * BPP - 1]);
    checks++; if (err_ovf !== 1'b0 || pif.pix_data !== model_pix(2 * BPP) || pix_cnt !== 4'd3) begin errors++; $display("FAIL bp_coincident: got ovf=%b data=%h cnt=%0d expected 0 %h 3", err_ovf, pif.pix_data, pix_cnt, model_pix(2 * BPP)); end
    send_range(3 * BPP, NPIX * BPP);
    tick(3);
    checks++; if (got_q.size() !== NPIX - 1) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), NPIX - 1); end
    for (int i = 0; i < NPIX - 1 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_pix%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fd_cnt !== 1 || busy !== 1'b0 || pix_cnt !== 4'(NPIX)) begin errors++; $display("FAIL bp_end: got pulses=%0d busy=%b cnt=%0d expected 1 0 %0d", fd_cnt, busy, pix_cnt, NPIX); end
  endtask

  task automatic test_timeout();
    got_q.delete(); fd_cnt = 0;
    pulse_start();
    tick(150);
    checks++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_wait_first: got busy=%b tmo=%b expected 1 0", busy, err_timeout); end
    send_byte(8'hA5);
    tick(TMO - 1);
    checks++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early: got tmo=%b busy=%b expected 0 1", err_timeout, busy); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_fire: got tmo=%b busy=%b expected 1 0", err_timeout, busy); end
    tick(20);
    checks++; if (fd_cnt !== 0 || got_q.size() !== 0 || err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_after: got pulses=%0d pix=%0d tmo=%b expected 0 0 1", fd_cnt, got_q.size(), err_timeout); end
    pulse_clr();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clr: got %b expected 0", err_timeout); end
    gen_random(NPIX * BPP);
    exp_q.delete(); got_q.delete(); fd_cnt = 0;
    build_expected(0, 0, NPIX);
    pulse_start();
    send_range(0, NPIX * BPP);
    tick(3);
    checks++; if (got_q.size() !== NPIX || fd_cnt !== 1 || err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_recover: got pix=%0d pulses=%0d tmo=%b expected %0d 1 0", got_q.size(), fd_cnt, err_timeout, NPIX); end
    for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tmo_pix%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_ignored();
    got_q.delete(); fd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      tick($urandom_range(0, 2));
    end
    checks++; if (pif.pix_valid !== 1'b0 || busy !== 1'b0 || pix_cnt !== 4'(NPIX)) begin errors++; $display("FAIL ign_idle: got valid=%b busy=%b cnt=%0d expected 0 0 %0d", pif.pix_valid, busy, pix_cnt, NPIX); end
    gen_random(NPIX * BPP + 1);
    exp_q.delete(); got_q.delete();
    build_expected(1, 0, NPIX);
    start = 1'b1; rx_data = bq[0]; rx_done = 1'b1;
    tick(1);
    start = 1'b0; rx_done = 1'b0;
    checks++; if (busy !== 1'b1 || pix_cnt !== 4'd0) begin errors++; $display("FAIL ign_start_byte: got busy=%b cnt=%0d expected 1 0", busy, pix_cnt); end
    send_range(1, 1 + 3 * BPP);
    pulse_start();
    checks++; if (pix_cnt !== 4'd3 || busy !== 1'b1) begin errors++; $display("FAIL ign_mid_start: got cnt=%0d busy=%b expected 3 1", pix_cnt, busy); end
    send_range(1 + 3 * BPP, 1 + NPIX * BPP);
    tick(3);
    checks++; if (got_q.size() !== NPIX || fd_cnt !== 1) begin errors++; $display("FAIL ign_frame: got pix=%0d pulses=%0d expected %0d 1", got_q.size(), fd_cnt, NPIX); end
    for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ign_pix%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    gen_random(NPIX * BPP);
    pif.pix_ready = 1'b0;
    pulse_start();
    send_range(0, 3 * BPP);
    checks++; if (pix_cnt !== 4'd3 || err_ovf !== 1'b1 || pif.pix_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: got cnt=%0d ovf=%b valid=%b expected 3 1 1", pix_cnt, err_ovf, pif.pix_valid); end
    fd_cnt = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (baud_set !== 4'd4 || pif.pix_data !== 16'h0 || pix_cnt !== 4'd0) begin errors++; $display("FAIL rst_data: got baud=%0d data=%h cnt=%0d expected 4 0000 0", baud_set, pif.pix_data, pix_cnt); end
    checks++; if ({pif.pix_valid, busy, frame_done, err_timeout, err_ovf} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b expected 00000", {pif.pix_valid, busy, frame_done, err_timeout, err_ovf}); end
    @(negedge clk);
    rst_n = 1'b1;
    pif.pix_ready = 1'b1;
    tick(5);
    checks++; if (fd_cnt !== 0 || busy !== 1'b0 || pif.pix_valid !== 1'b0) begin errors++; $display("FAIL rst_after: got pulses=%0d busy=%b valid=%b expected 0 0 0", fd_cnt, busy, pif.pix_valid); end
  endtask

`ifdef PIX_RGB888_EN
  task automatic test_rgb888();
    bq.delete();
    bq = '{8'hFF, 8'h80, 8'h08};
    pulse_start();
    send_range(0, 3);
    checks++; if (pif.pix_data !== 16'hFC01 || pif.pix_data !== model_pix(0)) begin errors++; $display("FAIL rgb888: got %h expected fc01", pif.pix_data); end
  endtask
`endif

  initial begin
    pif.pix_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    test_reset();
    test_frame();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_ignored();
    test_reset_midframe();
`ifdef PIX_RGB888_EN
    test_rgb888();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
